// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: serialises whole-line memory transactions from N_PORTS
// cache-side requesters onto the single external memory port.
// Optional feature macro: ARB_RR_EN. When it is defined, arbitration is
// round-robin. When it is undefined, arbitration is fixed priority and the
// lowest index wins.
// FSM: IDLE -> BUSY (memory request held until mem_ack) -> RESP (ack pulse) -> IDLE.

// Per-port helper. It marks a request as "at or after the round-robin
// pointer", so the top level can pick the first such port and wrap to the
// lowest requester when no port qualifies.
module mem_arbiter_rr_lane #(
  parameter int IDX_W = 2,
  parameter int IDX   = 0
) (
  input  logic             req,
  input  logic [IDX_W-1:0] ptr,
  output logic             hi
);
  localparam logic [IDX_W-1:0] MY_IDX = IDX_W'(IDX);

  assign hi = req && (MY_IDX >= ptr);
endmodule

module mem_arbiter_rr #(
  parameter int N_PORTS = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 128
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_PORTS-1:0]          req_valid,
  input  logic [N_PORTS-1:0]          req_rw,
  input  logic [N_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [N_PORTS*DATA_W-1:0]   req_wdata,
  output logic [N_PORTS-1:0]          req_ack,
  output logic [DATA_W-1:0]           rdata,
  output logic [2:0]                  grant_id,
  output logic                        busy,
  output logic                        mem_enable,
  output logic                        mem_rw,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_data_in,
  input  logic                        mem_ack,
  input  logic [DATA_W-1:0]           mem_data_out
);
  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PORTS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  state_t state, state_nxt;

  logic [N_PORTS-1:0][ADDR_W-1:0] addr_arr;
  logic [N_PORTS-1:0][DATA_W-1:0] wdata_arr;
  logic [N_PORTS-1:0]             hi_req;
  logic [IDX_W-1:0]               win_idx;
  logic [IDX_W-1:0]               gnt_idx;
  logic                           any_req;
  mem_req_t                       sel;

  assign addr_arr  = req_addr;
  assign wdata_arr = req_wdata;
  assign any_req   = |req_valid;

`ifdef ARB_RR_EN
  logic [IDX_W-1:0] rr_ptr;

  for (genvar i = 0; i < N_PORTS; i++) begin : g_lane
    mem_arbiter_rr_lane #(.IDX_W(IDX_W), .IDX(i)) u_lane (
      .req (req_valid[i]),
      .ptr (rr_ptr),
      .hi  (hi_req[i])
    );
  end

  // Move the pointer to the port after the winner, so the winner gets the lowest priority next time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rr_ptr <= '0;
    else if (state == IDLE && any_req)
      rr_ptr <= (win_idx == LAST_IDX) ? '0 : win_idx + IDX_W'(1);
  end
`else
  // Fixed priority: the search always starts at port 0.
  assign hi_req = req_valid;
`endif

  // Winner is the lowest port at or after the pointer. If no port qualifies, it wraps to the lowest requester.
  always_comb begin
    win_idx = '0;
    for (int i = N_PORTS - 1; i >= 0; i--)
      if (req_valid[i]) win_idx = IDX_W'(i);
    for (int i = N_PORTS - 1; i >= 0; i--)
      if (hi_req[i]) win_idx = IDX_W'(i);
    sel.rw    = req_rw[win_idx];
    sel.addr  = addr_arr[win_idx];
    sel.wdata = wdata_arr[win_idx];
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. mem_ack only matters in BUSY.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    if (mem_ack) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs. The memory request is latched at grant and stays frozen until mem_ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_enable  <= 1'b0;
      mem_rw      <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      req_ack     <= '0;
      rdata       <= '0;
      grant_id    <= '0;
      gnt_idx     <= '0;
      busy        <= 1'b0;
    end else begin
      req_ack <= '0;
      case (state)
        IDLE: if (any_req) begin
          mem_enable  <= 1'b1;
          mem_rw      <= sel.rw;
          mem_addr    <= sel.addr;
          mem_data_in <= sel.wdata;
          gnt_idx     <= win_idx;
          grant_id    <= 3'(win_idx);
          busy        <= 1'b1;
        end
        BUSY: if (mem_ack) begin
          if (!mem_rw) rdata <= mem_data_out;
          mem_enable <= 1'b0;
          req_ack    <= N_PORTS'(1) << gnt_idx;
        end
        RESP:    busy <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr (N_PORTS=3). It checks contention order
// for both the ARB_RR_EN build and the fixed-priority build.
module tb_mem_arbiter_rr;
  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   req_valid, req_rw, req_ack;
  logic [95:0]  req_addr;
  logic [383:0] req_wdata;
  logic [127:0] rdata, mem_data_in, mem_data_out;
  logic [2:0]   grant_id;
  logic         busy, mem_enable, mem_rw, mem_ack;
  logic [31:0]  mem_addr;

  int pass_cnt = 0;
  int total    = 0;

  localparam logic [127:0] L0 = 128'hDEADBEEF_00000000_00000000_00000000;
  localparam logic [127:0] L1 = 128'hDEADBEEF_00000000_00000000_00000001;
  localparam logic [127:0] LX = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
  localparam logic [127:0] W0 = 128'h11111111_11111111_11111111_11111111;
  localparam logic [127:0] W1 = 128'h22222222_22222222_22222222_22222222;
  localparam logic [127:0] W2 = 128'h55555555_55555555_55555555_55555555;

  mem_arbiter_rr #(.N_PORTS(3), .ADDR_W(32), .DATA_W(128)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(req_ack),
    .rdata(rdata), .grant_id(grant_id), .busy(busy), .mem_enable(mem_enable),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_ack(mem_ack), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    logic [2:0] order [6];
`ifdef ARB_RR_EN
    order = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
`else
    order = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
`endif
    reset        = 1'b0;
    req_valid    = 3'b111;
    req_rw       = 3'b100;
    req_addr     = {32'h80, 32'h40, 32'h100};
    req_wdata    = {W2, W1, W0};
    mem_ack      = 1'b0;
    mem_data_out = L0;

    // Reset held while every port requests.
    tick(); tick(); tick();
    chk("rst_enable", 128'(mem_enable), 0);
    chk("rst_rw",     128'(mem_rw), 0);
    chk("rst_addr",   128'(mem_addr), 0);
    chk("rst_wdata",  mem_data_in, 0);
    chk("rst_ack",    128'(req_ack), 0);
    chk("rst_rdata",  rdata, 0);
    chk("rst_grant",  128'(grant_id), 0);
    chk("rst_busy",   128'(busy), 0);

    // Release: port 0 wins. It then withdraws during BUSY, but the ack is still pulsed.
    reset = 1'b1;
    tick();
    chk("rel_enable", 128'(mem_enable), 1);
    chk("rel_grant",  128'(grant_id), 0);
    chk("rel_addr",   128'(mem_addr), 128'h100);
    chk("rel_busy",   128'(busy), 1);
    req_valid = 3'b000;
    tick();
    chk("wd_hold", 128'(mem_enable), 1);
    mem_ack = 1'b1;
    tick();
    chk("wd_ack",    128'(req_ack), 3'b001);
    chk("wd_rdata",  rdata, L0);
    chk("wd_enable", 128'(mem_enable), 0);
    chk("wd_busy",   128'(busy), 1);
    mem_ack = 1'b0;
    tick();
    chk("wd_ack_off", 128'(req_ack), 0);
    chk("wd_idle",    128'(busy), 0);

    // Single read from port 1 with a four-cycle memory.
    req_valid = 3'b010;
    tick();
    chk("rd_grant", 128'(grant_id), 1);
    chk("rd_rw",    128'(mem_rw), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rd_addr_stable", 128'(mem_addr), 128'h40);
      chk("rd_en_stable",   128'(mem_enable), 1);
    end
    mem_ack = 1'b1;
    mem_data_out = L1;
    tick();
    chk("rd_ack",   128'(req_ack), 3'b010);
    chk("rd_rdata", rdata, L1);
    mem_ack = 1'b0;
    req_valid = 3'b000;
    tick();
    chk("rd_ack_pulse", 128'(req_ack), 0);
    chk("rd_rdata_hold", rdata, L1);

    // Single write from port 2. rdata must not change.
    req_valid = 3'b100;
    tick();
    chk("wr_grant", 128'(grant_id), 2);
    chk("wr_rw",    128'(mem_rw), 1);
    chk("wr_addr",  128'(mem_addr), 128'h80);
    chk("wr_data",  mem_data_in, W2);
    mem_ack = 1'b1;
    mem_data_out = LX;
    tick();
    chk("wr_ack",   128'(req_ack), 3'b100);
    chk("wr_rdata", rdata, L1);
    mem_ack = 1'b0;
    req_valid = 3'b000;
    tick();

    // Contention: all ports request continuously, and memory is single-cycle.
    req_valid = 3'b111;
    for (int t = 0; t < 6; t++) begin
      tick();
      chk("ct_grant",  128'(grant_id), 128'(order[t]));
      chk("ct_enable", 128'(mem_enable), 1);
      mem_ack = 1'b1;
      tick();
      chk("ct_ack", 128'(req_ack), 128'(3'b001 << order[t]));
      mem_ack = 1'b0;
      tick();
      chk("ct_idle_gap", 128'(mem_enable), 0);
    end
    req_valid = 3'b000;

    // Spurious mem_ack in IDLE with no requests.
    tick();
    mem_ack = 1'b1;
    tick(); tick();
    chk("sp_ack",    128'(req_ack), 0);
    chk("sp_busy",   128'(busy), 0);
    chk("sp_enable", 128'(mem_enable), 0);
    mem_ack = 1'b0;

    // Reset in BUSY after a port-1 grant, which moves the pointer away from 0.
    req_valid = 3'b010;
    tick();
    chk("rb_grant", 128'(grant_id), 1);
    req_valid = 3'b000;
    #2 reset = 1'b0;
    #1;
    chk("rb_async_enable", 128'(mem_enable), 0);
    chk("rb_async_busy",   128'(busy), 0);
    mem_ack = 1'b1;
    tick();
    chk("rb_no_ack", 128'(req_ack), 0);
    mem_ack = 1'b0;
    reset = 1'b1;
    req_valid = 3'b101;
    tick();
    chk("rb_regrant", 128'(grant_id), 0);
    chk("rb_addr",    128'(mem_addr), 128'h100);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
